// File: rtl/register_file.sv
// register_file: 2^A x N register file with one synchronous write port and
// two independent combinational read ports. Word 0 is hardwired to zero and
// is not backed by storage. Each read port is a binary 2^A-to-1 mux tree.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the in-flight write
// data to any read port addressing the word being written in the same cycle.
// Without it, a same-cycle read returns the value stored before the edge.
//
// Interface timing: there is no handshake. A write presented with wr_ena=1
// is committed at the next rising clk edge unless rst is high on that edge,
// in which case every word is cleared and the write is dropped.
module register_file #(
  parameter int N = 32,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [A-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [A-1:0] rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [A-1:0] rd_addr1,
  output logic [N-1:0] rd_data1
);

  localparam int DEPTH = 1 << A;

  // Only words 1..DEPTH-1 hold state; word 0 is a constant zero leaf.
  logic [DEPTH-1:1][N-1:0] regs_q;
  logic [DEPTH-1:1][N-1:0] regs_d;

  // Mux leaves: word 0 is zero, words 1.. come from storage.
  logic [DEPTH-1:0][N-1:0] leaves;
  logic [N-1:0]            mux0;
  logic [N-1:0]            mux1;

  assign leaves = {regs_q, {N{1'b0}}};

  // Binary mux tree, reduced in place: level l pairs adjacent entries using
  // address bit l, halving the live entries each level until one remains.
  // Writing entry i only after reading entries 2i and 2i+1 keeps the in-place
  // reduction safe because i <= 2i.
  function automatic logic [N-1:0] mux_tree(
    input logic [DEPTH-1:0][N-1:0] words,
    input logic [A-1:0]            sel
  );
    logic [DEPTH-1:0][N-1:0] stage;
    stage = words;
    for (int l = 0; l < A; l++) begin
      for (int i = 0; i < DEPTH / 2; i++) begin
        if (i < (DEPTH >> (l + 1))) begin
          stage[i] = sel[l] ? stage[2*i+1] : stage[2*i];
        end
      end
    end
    return stage[0];
  endfunction

  // Next-state: the addressed word takes the write data; writes to word 0 vanish.
  always_comb begin
    regs_d = regs_q;
    if (wr_ena && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage update; reset wins over a write presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read-port multiplexers from stored state.
  always_comb begin
    mux0 = mux_tree(leaves, rd_addr0);
    mux1 = mux_tree(leaves, rd_addr1);
  end

`ifdef REGFILE_BYPASS_EN
  // A write is forwardable only when it will actually be committed.
  logic fwd_ok;
  assign fwd_ok = wr_ena && !rst && (wr_addr != '0);

  // Per-port forwarding of the in-flight write data.
  always_comb begin
    rd_data0 = (fwd_ok && (rd_addr0 == wr_addr)) ? wr_data : mux0;
    rd_data1 = (fwd_ok && (rd_addr1 == wr_addr)) ? wr_data : mux1;
  end
`else
  // Reads reflect stored state only.
  always_comb begin
    rd_data0 = mux0;
    rd_data1 = mux1;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file. A 32x32 instance
// runs directed and random traffic against a reference array; an 8-bit,
// 8-word instance exercises the parametrisation.
module tb_register_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 32x32 instance ----------------
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [31:0] rd_data0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data1;

  register_file #(.N(32), .A(5)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  // ---------------- 8x8 instance ----------------
  logic       s_wr_ena;
  logic [2:0] s_wr_addr;
  logic [7:0] s_wr_data;
  logic [2:0] s_rd_addr0;
  logic [7:0] s_rd_data0;
  logic [2:0] s_rd_addr1;
  logic [7:0] s_rd_data1;

  register_file #(.N(8), .A(3)) u_small (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (s_wr_ena),
    .wr_addr  (s_wr_addr),
    .wr_data  (s_wr_data),
    .rd_addr0 (s_rd_addr0),
    .rd_data0 (s_rd_data0),
    .rd_addr1 (s_rd_addr1),
    .rd_data1 (s_rd_data1)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pop the two expected values (port 0 then port 1) and compare.
  task automatic sample_pair(input string tag, input logic [31:0] got0, input logic [31:0] got1);
    logic [31:0] e;
    if (exp_q.size() < 2) begin
      errors++;
      $display("FAIL %s scoreboard underflow size=%0d", tag, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_p0"}, got0, e);
      e = exp_q.pop_front();
      check_eq({tag, "_p1"}, got1, e);
    end
  endtask

  // Expected pre-edge read value from the reference array and current inputs.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_ena && !rst && (wr_addr != 5'd0) && (a == wr_addr)) v = wr_data;
`endif
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with inputs already driven. Pushes expectations,
  // samples on the falling edge, then advances the reference on the next edge.
  task automatic drive_cycle(input string tag, input bit use_model,
                             input logic [31:0] c0, input logic [31:0] c1);
    if (use_model) begin
      exp_q.push_back(model_read(rd_addr0));
      exp_q.push_back(model_read(rd_addr1));
    end else begin
      exp_q.push_back(c0);
      exp_q.push_back(c1);
    end
    @(negedge clk);
    sample_pair(tag, rd_data0, rd_data1);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wr_ena && (wr_addr != 5'd0)) begin
      model[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic set_write(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_ena  = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic set_read(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr0 = a0;
    rd_addr1 = a1;
  endtask

  function automatic logic [31:0] small_exp(input int a);
    return (a == 0) ? 32'h0 : 32'(a + 16);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] hz;
    rst = 1'b1;
    set_write(1'b0, 5'd0, 32'h0);
    set_read(5'd0, 5'd0);
    s_wr_ena = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd_addr0 = '0; s_rd_addr1 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;

    // Address 0 reads zero even before any reset edge.
    #2;
    check_eq("pre_reset_addr0_p0", rd_data0, 32'h0);
    check_eq("pre_reset_addr0_p1", rd_data1, 32'h0);

    @(posedge clk); #1;
    // Reset edge under bench control, then sweep every address.
    drive_cycle("reset_hold", 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_read(5'(a), 5'(31 - a));
      drive_cycle("reset_zero", 1'b0, 32'h0, 32'h0);
    end

    // Write then read.
    set_write(1'b1, 5'd5, 32'hDEADBEEF);
    set_read(5'd5, 5'd6);
    drive_cycle("wr5_same_cycle", 1'b1, 32'h0, 32'h0);
    set_write(1'b0, 5'd0, 32'h0);
    set_read(5'd5, 5'd5);
    drive_cycle("wr5_readback", 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    set_read(5'd6, 5'd5);
    drive_cycle("addr6_untouched", 1'b0, 32'h0, 32'hDEADBEEF);

    // Register 0 is immutable.
    set_write(1'b1, 5'd0, 32'hFFFFFFFF);
    set_read(5'd0, 5'd0);
    drive_cycle("r0_write_before", 1'b0, 32'h0, 32'h0);
    set_write(1'b0, 5'd0, 32'h0);
    drive_cycle("r0_write_after", 1'b0, 32'h0, 32'h0);

    // Same-cycle write/read hazard on address 7.
    set_write(1'b1, 5'd7, 32'h11111111);
    set_read(5'd1, 5'd2);
    drive_cycle("hz_setup", 1'b1, 32'h0, 32'h0);
`ifdef REGFILE_BYPASS_EN
    hz = 32'h22222222;
`else
    hz = 32'h11111111;
`endif
    set_write(1'b1, 5'd7, 32'h22222222);
    set_read(5'd7, 5'd7);
    drive_cycle("hz_before_edge", 1'b0, hz, hz);
    set_write(1'b0, 5'd0, 32'h0);
    drive_cycle("hz_after_edge", 1'b0, 32'h22222222, 32'h22222222);

    // Reset priority over a simultaneous write.
    set_write(1'b1, 5'd3, 32'hA5A5A5A5);
    set_read(5'd7, 5'd5);
    drive_cycle("rp_setup", 1'b0, 32'h22222222, 32'hDEADBEEF);
    rst = 1'b1;
    set_write(1'b1, 5'd3, 32'h12345678);
    set_read(5'd3, 5'd3);
    drive_cycle("rp_before_edge", 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    rst = 1'b0;
    set_write(1'b0, 5'd0, 32'h0);
    set_read(5'd3, 5'd7);
    drive_cycle("rp_after_edge", 1'b0, 32'h0, 32'h0);

    // Write on the first edge after reset release is performed.
    rst = 1'b1;
    set_read(5'd9, 5'd9);
    drive_cycle("rel_hold", 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    set_write(1'b1, 5'd9, 32'h0BADF00D);
    drive_cycle("rel_write", 1'b1, 32'h0, 32'h0);
    set_write(1'b0, 5'd0, 32'h0);
    drive_cycle("rel_readback", 1'b0, 32'h0BADF00D, 32'h0BADF00D);

    // Random traffic against the reference array.
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      drive_cycle("rand", 1'b1, 32'h0, 32'h0);
    end
    rst = 1'b0;
    set_write(1'b0, 5'd0, 32'h0);

    // Small instance: fill words 1..7 with i+0x10, then read in pairs.
    for (int i = 1; i < 8; i++) begin
      s_wr_ena  = 1'b1;
      s_wr_addr = 3'(i);
      s_wr_data = 8'(i + 16);
      @(posedge clk); #1;
    end
    s_wr_ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_rd_addr0 = 3'(i);
      s_rd_addr1 = 3'(7 - i);
      exp_q.push_back(small_exp(i));
      exp_q.push_back(small_exp(7 - i));
      @(negedge clk);
      sample_pair("small", {24'h0, s_rd_data0}, {24'h0, s_rd_data1});
      @(posedge clk); #1;
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover size=%0d", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file for the single-cycle CPU datapath: 2^A words of N bits, one synchronous write port and two independent read ports. Each read port is built from a 2^A-to-1 word multiplexer tree, the generalised form of the team's fixed 32-input mux. It sits between instruction decode and the ALU, supplying rs/rt operands and accepting the writeback result.

## Interface
- N, 32, word width in bits (≥1)
- A, 5, address width; depth = 2^A words (1..6)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wr_ena  input  1  write enable
- wr_addr  input  A  write address
- wr_data  input  N  write data
- rd_addr0  input  A  read port 0 address
- rd_data0  output  N  read port 0 data
- rd_addr1  input  A  read port 1 address
- rd_data1  output  N  read port 1 data

Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.

## Operation
- Storage: 2^A registers `r[0..2^A-1]`, each N bits.
- Register 0 is hardwired zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 regardless of stored state.
- Write: on rising clk, if `!rst && wr_ena && wr_addr != 0`, then `r[wr_addr] <= wr_data`. All other registers hold.
- Reset: on rising clk with rst=1, every register becomes 0. rst has priority over wr_ena in the same cycle, so that write is lost.
- Read: combinational. `rd_dataK = (rd_addrK == 0) ? 0 : r[rd_addrK]`.
  - Ports 0 and 1 are fully independent.
  - Both ports may address the same word at once.
- No error or out-of-range condition exists: every A-bit address is valid.

## Timing
- Write latency: 1 cycle. Data presented at edge k is visible on reads after edge k, i.e. during cycle k+1.
- Read latency: 0 cycles (combinational from rd_addrK and register state).
- Outputs during and after reset:
  - rd_data0 and rd_data1 read 0 for every address after the first rst edge.
  - Before the first reset edge, contents are undefined, except that address 0 always reads 0.
- Same-cycle write and read of one address (without bypass): the read returns the old value. The new value appears after the edge.
- Reset asserted mid-stream: the clearing takes effect at the next edge. A write that is pending in the same cycle is dropped.
- Reset deasserted with wr_ena=1: the write on that first non-reset edge is performed normally.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-to-read forwarding is enabled. If `wr_ena && !rst && wr_addr != 0 && rd_addrK == wr_addr`, then rd_dataK = wr_data combinationally in the same cycle. Forwarding applies per port, independently on each.
  - No forwarding to address 0.
  - No forwarding while rst=1.
- Undefined: there is no forwarding, and reads always reflect stored state as described in Operation.
- The storage update rule is identical in both builds.

## Test plan
- Reset and zero: assert rst for 1 edge, then read all 32 addresses on both ports -> every read is 0x00000000.
- Write then read: write 0xDEADBEEF to addr 5, then read addr 5 on port 0 and port 1 next cycle -> both ports show 0xDEADBEEF. Addr 6 still reads 0.
- Register 0 immutable: write 0xFFFFFFFF to addr 0 -> reads of addr 0 return 0 before and after the edge.
- Same-cycle hazard: r[7]=0x11111111; in one cycle write 0x22222222 to addr 7 while reading addr 7.
  - Without bypass: 0x11111111 before the edge, 0x22222222 after.
  - With `REGFILE_BYPASS_EN`: 0x22222222 before the edge.
- Reset priority: r[3]=0xA5A5A5A5; in one cycle assert rst=1 with wr_ena=1, wr_addr=3, wr_data=0x12345678 -> after the edge addr 3 reads 0.
- Parametrisation: instantiate N=8, A=3 and write value i+0x10 to each addr i=1..7.
  - Each address reads back i+0x10.
  - Addr 0 reads 0x00.
  - Port 0 and port 1 on different addresses return their respective values in the same cycle.
